// File: rtl/ppg_window_stats.sv
// Windowed min/max tracker for the RED/IR PPG channels; publishes AC, DC and clip
// flags once per WIN_LEN sample pairs for the SpO2 ratio stage.
module ppg_window_stats #(
  parameter int unsigned WIN_LEN = 100,
  parameter int unsigned CLIP_LO = 5,
  parameter int unsigned CLIP_HI = 250
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sample_valid,
  input  logic [7:0] RED_ADC_Value,
  input  logic [7:0] IR_ADC_Value,
  output logic [7:0] RED_AC,
  output logic [7:0] RED_DC,
  output logic [7:0] IR_AC,
  output logic [7:0] IR_DC,
  output logic       RED_clip,
  output logic       IR_clip,
  output logic       win_valid
);

  localparam logic [7:0] WinLenC = 8'(WIN_LEN);
  localparam logic [7:0] ClipLoC = 8'(CLIP_LO);
  localparam logic [7:0] ClipHiC = 8'(CLIP_HI);

  typedef enum logic [1:0] {StIdle, StAccum, StPublish} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] red_min_q, red_min_d, red_max_q, red_max_d;
  logic [7:0] ir_min_q, ir_min_d, ir_max_q, ir_max_d;
  logic       red_clip_acc_q, red_clip_acc_d, ir_clip_acc_q, ir_clip_acc_d;
  logic [7:0] red_ac_q, red_ac_d, red_dc_q, red_dc_d;
  logic [7:0] ir_ac_q, ir_ac_d, ir_dc_q, ir_dc_d;
  logic       red_clip_q, red_clip_d, ir_clip_q, ir_clip_d;
  logic       win_valid_q, win_valid_d;

  logic       red_s_clip, ir_s_clip;
  logic [8:0] red_sum, ir_sum;

  assign red_s_clip = (RED_ADC_Value < ClipLoC) || (RED_ADC_Value > ClipHiC);
  assign ir_s_clip  = (IR_ADC_Value < ClipLoC) || (IR_ADC_Value > ClipHiC);
  assign red_sum    = {1'b0, red_max_q} + {1'b0, red_min_q};
  assign ir_sum     = {1'b0, ir_max_q} + {1'b0, ir_min_q};

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    red_min_d      = red_min_q;
    red_max_d      = red_max_q;
    ir_min_d       = ir_min_q;
    ir_max_d       = ir_max_q;
    red_clip_acc_d = red_clip_acc_q;
    ir_clip_acc_d  = ir_clip_acc_q;
    red_ac_d       = red_ac_q;
    red_dc_d       = red_dc_q;
    ir_ac_d        = ir_ac_q;
    ir_dc_d        = ir_dc_q;
    red_clip_d     = red_clip_q;
    ir_clip_d      = ir_clip_q;
    win_valid_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (enable) state_d = StAccum;
      end
      StAccum: begin
        if (!enable) begin
          // Partial window is discarded
          state_d        = StIdle;
          cnt_d          = 8'd0;
          red_min_d      = 8'hff;
          red_max_d      = 8'h00;
          ir_min_d       = 8'hff;
          ir_max_d       = 8'h00;
          red_clip_acc_d = 1'b0;
          ir_clip_acc_d  = 1'b0;
        end else if (sample_valid) begin
          if (RED_ADC_Value < red_min_q) red_min_d = RED_ADC_Value;
          if (RED_ADC_Value > red_max_q) red_max_d = RED_ADC_Value;
          if (IR_ADC_Value < ir_min_q)   ir_min_d  = IR_ADC_Value;
          if (IR_ADC_Value > ir_max_q)   ir_max_d  = IR_ADC_Value;
          red_clip_acc_d = red_clip_acc_q | red_s_clip;
          ir_clip_acc_d  = ir_clip_acc_q | ir_s_clip;
          cnt_d          = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == WinLenC) state_d = StPublish;
        end
      end
      StPublish: begin
        red_ac_d       = red_max_q - red_min_q;
        red_dc_d       = red_sum[8:1];
        ir_ac_d        = ir_max_q - ir_min_q;
        ir_dc_d        = ir_sum[8:1];
        red_clip_d     = red_clip_acc_q;
        ir_clip_d      = ir_clip_acc_q;
        win_valid_d    = 1'b1;
        cnt_d          = 8'd0;
        red_min_d      = 8'hff;
        red_max_d      = 8'h00;
        ir_min_d       = 8'hff;
        ir_max_d       = 8'h00;
        red_clip_acc_d = 1'b0;
        ir_clip_acc_d  = 1'b0;
        if (!enable) begin
          state_d = StIdle;
        end else begin
          state_d = StAccum;
          // A sample arriving now opens the next window
          if (sample_valid) begin
            cnt_d          = 8'd1;
            red_min_d      = RED_ADC_Value;
            red_max_d      = RED_ADC_Value;
            ir_min_d       = IR_ADC_Value;
            ir_max_d       = IR_ADC_Value;
            red_clip_acc_d = red_s_clip;
            ir_clip_acc_d  = ir_s_clip;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= 8'd0;
      red_min_q      <= 8'hff;
      red_max_q      <= 8'h00;
      ir_min_q       <= 8'hff;
      ir_max_q       <= 8'h00;
      red_clip_acc_q <= 1'b0;
      ir_clip_acc_q  <= 1'b0;
      red_ac_q       <= 8'd0;
      red_dc_q       <= 8'd0;
      ir_ac_q        <= 8'd0;
      ir_dc_q        <= 8'd0;
      red_clip_q     <= 1'b0;
      ir_clip_q      <= 1'b0;
      win_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      red_min_q      <= red_min_d;
      red_max_q      <= red_max_d;
      ir_min_q       <= ir_min_d;
      ir_max_q       <= ir_max_d;
      red_clip_acc_q <= red_clip_acc_d;
      ir_clip_acc_q  <= ir_clip_acc_d;
      red_ac_q       <= red_ac_d;
      red_dc_q       <= red_dc_d;
      ir_ac_q        <= ir_ac_d;
      ir_dc_q        <= ir_dc_d;
      red_clip_q     <= red_clip_d;
      ir_clip_q      <= ir_clip_d;
      win_valid_q    <= win_valid_d;
    end
  end

  assign RED_AC    = red_ac_q;
  assign RED_DC    = red_dc_q;
  assign IR_AC     = ir_ac_q;
  assign IR_DC     = ir_dc_q;
  assign RED_clip  = red_clip_q;
  assign IR_clip   = ir_clip_q;
  assign win_valid = win_valid_q;

endmodule

// File: tb/tb_ppg_window_stats.sv
// Scoreboard bench for ppg_window_stats: stimulus queues expected window results,
// a negedge monitor pops and compares them on every win_valid pulse.
module tb_ppg_window_stats;

  localparam int unsigned WinLen = 4;

  logic       CLK = 1'b0;
  logic       rst_n, enable, sample_valid;
  logic [7:0] red_in, ir_in;
  logic [7:0] red_ac, red_dc, ir_ac, ir_dc;
  logic       red_clip, ir_clip, win_valid;

  typedef struct packed {
    logic [7:0] red_ac;
    logic [7:0] red_dc;
    logic [7:0] ir_ac;
    logic [7:0] ir_dc;
    logic       red_clip;
    logic       ir_clip;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   pulse_cyc[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  ppg_window_stats #(
    .WIN_LEN(WinLen),
    .CLIP_LO(5),
    .CLIP_HI(250)
  ) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_valid (sample_valid),
    .RED_ADC_Value(red_in),
    .IR_ADC_Value (ir_in),
    .RED_AC       (red_ac),
    .RED_DC       (red_dc),
    .IR_AC        (ir_ac),
    .IR_DC        (ir_dc),
    .RED_clip     (red_clip),
    .IR_clip      (ir_clip),
    .win_valid    (win_valid)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Monitor: every win_valid pulse must match the oldest queued expectation
  always @(negedge CLK) begin
    if (win_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_win_valid: got pulse at cycle %0d, expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("red_ac", int'(red_ac), int'(mon_e.red_ac));
        check("red_dc", int'(red_dc), int'(mon_e.red_dc));
        check("ir_ac", int'(ir_ac), int'(mon_e.ir_ac));
        check("ir_dc", int'(ir_dc), int'(mon_e.ir_dc));
        check("red_clip", int'(red_clip), int'(mon_e.red_clip));
        check("ir_clip", int'(ir_clip), int'(mon_e.ir_clip));
      end
    end
  end

  task automatic expect_win(input int rac, input int rdc, input int iac, input int idc,
                            input int rc, input int ic);
    exp_t e;
    e.red_ac   = 8'(rac);
    e.red_dc   = 8'(rdc);
    e.ir_ac    = 8'(iac);
    e.ir_dc    = 8'(idc);
    e.red_clip = 1'(rc);
    e.ir_clip  = 1'(ic);
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] i);
    @(negedge CLK);
    sample_valid = 1'b1;
    red_in       = r;
    ir_in        = i;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      sample_valid = 1'b0;
    end
  endtask

  // Bounded wait for all queued windows, then a quiet period to catch stray pulses
  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    idle(6);
    check({"pending_", name}, exp_q.size(), 0);
  endtask

  task automatic check_spacing(input string name, input int n_pulses);
    check({"pulses_", name}, pulse_cyc.size(), n_pulses);
    for (int i = 1; i < pulse_cyc.size(); i++)
      check({"spacing_", name}, pulse_cyc[i] - pulse_cyc[i-1], int'(WinLen));
  endtask

  task automatic check_zero(input string name);
    check({name, "_red_ac"}, int'(red_ac), 0);
    check({name, "_red_dc"}, int'(red_dc), 0);
    check({name, "_ir_ac"}, int'(ir_ac), 0);
    check({name, "_ir_dc"}, int'(ir_dc), 0);
    check({name, "_red_clip"}, int'(red_clip), 0);
    check({name, "_ir_clip"}, int'(ir_clip), 0);
    check({name, "_win_valid"}, int'(win_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no completion by 100000 time units, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    sample_valid = 1'b0;
    red_in       = 8'd0;
    ir_in        = 8'd0;
    #12;
    check_zero("reset");
    @(negedge CLK);
    rst_n = 1'b1;

    // 1: basic window
    @(negedge CLK);
    enable = 1'b1;
    expect_win(40, 120, 10, 55, 0, 0);
    send(100, 50); send(140, 60); send(120, 55); send(110, 52);
    idle(1);
    drain("t1");

    // 2: full-scale RED swing, constant IR
    expect_win(255, 127, 0, 100, 1, 0);
    send(0, 100); send(255, 100); send(10, 100); send(200, 100);
    idle(1);
    drain("t2");

    // 3: sample during PUBLISH starts the next window (IR at clip boundaries)
    pulse_cyc.delete();
    expect_win(30, 45, 0, 250, 0, 0);
    expect_win(13, 83, 3, 6, 0, 0);
    send(30, 250); send(40, 250); send(50, 250); send(60, 250);
    send(77, 5); send(90, 6); send(80, 7); send(85, 8);
    idle(1);
    drain("t3");
    check_spacing("t3", 2);

    // 4: enable dropped mid-window, ignored sample while disabled, fresh window
    send(0, 0); send(255, 255);
    idle(1);
    enable = 1'b0;
    send(0, 0);
    idle(2);
    check("hold_red_ac", int'(red_ac), 13);
    check("hold_red_dc", int'(red_dc), 83);
    enable = 1'b1;
    expect_win(30, 215, 26, 17, 0, 1);
    send(200, 4); send(210, 10); send(220, 20); send(230, 30);
    idle(1);
    drain("t4");

    // 5: asynchronous reset mid-window
    send(50, 50); send(60, 60);
    idle(1);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge CLK);
    rst_n = 1'b1;
    expect_win(3, 2, 0, 128, 1, 0);
    send(1, 128); send(2, 128); send(3, 128); send(4, 128);
    idle(1);
    drain("t5");

    // 6: three back-to-back windows
    pulse_cyc.delete();
    expect_win(30, 25, 30, 45, 0, 0);
    expect_win(0, 255, 0, 0, 1, 1);
    expect_win(3, 101, 30, 185, 0, 0);
    send(10, 60); send(20, 50); send(30, 40); send(40, 30);
    send(255, 0); send(255, 0); send(255, 0); send(255, 0);
    send(100, 200); send(101, 190); send(102, 180); send(103, 170);
    idle(1);
    drain("t6");
    check_spacing("t6", 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
